// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared constants and types for the beamformer delay path
package beam_pkg;

  localparam int DW        = 19;
  localparam int NUM_CH    = 8;
  localparam int MAX_DELAY = 64;

  typedef logic signed [DW-1:0] pcm_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_OUT
  } state_t;

endpackage

// File: rtl/delay_ram.sv
// rtl/delay_ram.sv - single-port synchronous sample RAM, one-cycle read latency
module delay_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 19
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds while the controller stalls
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/beam_delay_sched.sv
// rtl/beam_delay_sched.sv - time-multiplexed per-channel frame delay over one shared RAM
module beam_delay_sched #(
  parameter int NUM_CH    = beam_pkg::NUM_CH,
  parameter int MAX_DELAY = beam_pkg::MAX_DELAY,
  parameter int DW        = beam_pkg::DW,
  parameter int CHW       = $clog2(NUM_CH),
  parameter int AW        = $clog2(MAX_DELAY)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  input  logic           cfg_valid,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [AW-1:0]  cfg_delay,
  output logic           seq_err
);

  import beam_pkg::*;

  localparam int             RAW      = CHW + AW;
  localparam logic [AW-1:0]  FILL_MAX = AW'(MAX_DELAY - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);

  state_t         state, state_nxt;
  logic [CHW-1:0] ch, exp_ch;
  logic [DW-1:0]  data;
  logic [AW-1:0]  wptr, fill_cnt;
  logic [AW-1:0]  shadow [NUM_CH];
  logic [AW-1:0]  active [NUM_CH];
  logic           fill_ok;
  logic           ram_en, ram_we;
  logic [RAW-1:0] ram_addr;
  logic [DW-1:0]  ram_q;
  logic           accept, drop, out_fire;

  assign accept   = (state == S_IDLE) && in_valid && (in_ch == exp_ch);
  assign drop     = (state == S_IDLE) && in_valid && (in_ch != exp_ch);
  assign out_fire = (state == S_OUT) && out_ready;

  // Samples older than the ring history are masked to zero rather than read stale
  assign out_data = fill_ok ? ram_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ch, wptr};
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = S_WR;
      end
      S_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        state_nxt = S_RD;
      end
      S_RD: begin
        ram_en    = 1'b1;
        ram_addr  = {ch, wptr - active[ch]};
        state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch       <= '0;
      data     <= '0;
      exp_ch   <= '0;
      wptr     <= '0;
      fill_cnt <= '0;
      fill_ok  <= 1'b0;
      out_ch   <= '0;
      seq_err  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      seq_err <= drop;
      if (cfg_valid) shadow[cfg_ch] <= cfg_delay;
      if (accept) begin
        ch   <= in_ch;
        data <= in_data;
        // Frame commit samples the pre-edge shadow, so a same-cycle cfg lands next frame
        if (in_ch == '0) begin
          for (int i = 0; i < NUM_CH; i++) active[i] <= shadow[i];
        end
      end
      if (state == S_RD) begin
        fill_ok <= (fill_cnt >= active[ch]);
        out_ch  <= ch;
      end
      if (out_fire) begin
        exp_ch <= ch + CHW'(1);
        if (ch == LAST_CH) begin
          wptr <= wptr + AW'(1);
          if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + AW'(1);
        end
      end
    end
  end

  delay_ram #(
    .DEPTH(NUM_CH * MAX_DELAY),
    .AW   (RAW),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_beam_delay_sched.sv
// tb/tb_beam_delay_sched.sv - scoreboard bench for beam_delay_sched
module tb_beam_delay_sched;
  import beam_pkg::*;

  localparam int NCH  = 4;
  localparam int MAXD = 8;
  localparam int CW   = $clog2(NCH);
  localparam int AW   = $clog2(MAXD);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ch = '0;
  pcm_t          in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_ch;
  pcm_t          out_data;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [AW-1:0] cfg_delay = '0;
  logic          seq_err;

  int checks = 0;
  int failures = 0;

  beam_delay_sched #(
    .NUM_CH(NCH), .MAX_DELAY(MAXD), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [CW-1:0] ch;
    pcm_t          data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] m_shadow [NCH];
  logic [AW-1:0] m_active [NCH];
  pcm_t          hist [NCH][64];
  int            m_frame;
  logic [CW-1:0] m_exp;

  function automatic pcm_t gen(input int base, input int c, input int k);
    if (c == 3) return pcm_t'(-(base + k));
    return pcm_t'(base + 100 * c + k);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_frame = 0;
    m_exp = '0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [CW-1:0] c, input pcm_t d, input bit ce,
                              input logic [CW-1:0] cc, input logic [AW-1:0] cd);
    exp_t e;
    if (c == m_exp) begin
      if (c == '0) begin
        for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
      end
      hist[c][m_frame] = d;
      e.ch = c;
      e.data = (m_frame >= int'(m_active[c])) ? hist[c][m_frame - int'(m_active[c])] : '0;
      sb.push_back(e);
      if (int'(c) == NCH - 1) m_frame++;
      m_exp = CW'(int'(c) + 1);
    end
    if (ce) m_shadow[cc] = cd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic do_cfg(input int c, input int d);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_ch = CW'(c);
    cfg_delay = AW'(d);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_shadow[c] = AW'(d);
  endtask

  task automatic drive_in(input logic [CW-1:0] c, input pcm_t d, input bit ce,
                          input logic [CW-1:0] cc, input logic [AW-1:0] cd, output bit acc);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ch = c;
    in_data = d;
    cfg_valid = ce;
    cfg_ch = cc;
    cfg_delay = cd;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) model_accept(c, d, ce, cc, cd);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok, output int lat, output logic [CW-1:0] och, output pcm_t od);
    ok = 1'b0;
    lat = 0;
    och = '0;
    od = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid && lat == 0) lat = i;
      if (out_valid && out_ready) begin
        ok = 1'b1;
        och = out_ch;
        od = out_data;
        break;
      end
    end
  endtask

  task automatic xfer(input int c, input pcm_t d, input bit ce, input int cc, input int cd,
                      output bit ok, output int lat, output logic [CW-1:0] och,
                      output pcm_t od, output exp_t e);
    bit acc;
    drive_in(CW'(c), d, ce, CW'(cc), AW'(cd), acc);
    ok = 1'b0;
    lat = 0;
    och = '0;
    od = '0;
    e = '0;
    if (!acc) return;
    wait_out(ok, lat, och, od);
    if (ok && sb.size() > 0) e = sb.pop_front();
    else ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if ({out_valid, seq_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got out_valid=%b seq_err=%b exp 0 0", out_valid, seq_err);
    end
    checks++;
    if (out_ch !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_out got ch=%0d data=%0d exp 0 0", out_ch, out_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    bit ok; int lat; logic [CW-1:0] och; pcm_t od; exp_t e;
    for (int c = 0; c < NCH; c++) begin
      xfer(c, pcm_t'((c + 1) * 100), 1'b0, 0, 0, ok, lat, och, od, e);
      checks++;
      if (!ok || och !== e.ch || od !== e.data || lat != 3) begin
        failures++;
        $display("FAIL basic_out ch%0d got ch=%0d data=%0d lat=%0d exp ch=%0d data=%0d lat=3",
                 c, och, od, lat, e.ch, e.data);
      end
      checks++;
      if (od !== pcm_t'((c + 1) * 100)) begin
        failures++;
        $display("FAIL basic_value ch%0d got=%0d exp=%0d", c, od, (c + 1) * 100);
      end
    end
  endtask

  task automatic test_delay();
    bit ok; int lat; logic [CW-1:0] och; pcm_t od; exp_t e; pcm_t d;
    int exp_ch1[5];
    exp_ch1[0] = 0; exp_ch1[1] = 0; exp_ch1[2] = 1; exp_ch1[3] = 11; exp_ch1[4] = 21;
    do_reset();
    do_cfg(1, 2);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < NCH; c++) begin
        d = (c == 1) ? pcm_t'(10 * k + 1) : gen(2000, c, k);
        xfer(c, d, 1'b0, 0, 0, ok, lat, och, od, e);
        checks++;
        if (!ok || och !== e.ch || od !== e.data) begin
          failures++;
          $display("FAIL delay_out f%0d ch%0d got ch=%0d data=%0d exp ch=%0d data=%0d",
                   k, c, och, od, e.ch, e.data);
        end
        if (c == 1) begin
          checks++;
          if (od !== pcm_t'(exp_ch1[k])) begin
            failures++;
            $display("FAIL delay_ch1 f%0d got=%0d exp=%0d", k, od, exp_ch1[k]);
          end
        end
      end
    end
  endtask

  task automatic test_cfg_commit();
    bit ok; int lat; logic [CW-1:0] och; pcm_t od; exp_t e; pcm_t d;
    for (int k = 5; k < 7; k++) begin
      for (int c = 0; c < NCH; c++) begin
        d = (c == 1) ? pcm_t'(10 * k + 1) : gen(2000, c, k);
        xfer(c, d, (k == 5 && c == 0), 2, 3, ok, lat, och, od, e);
        checks++;
        if (!ok || och !== e.ch || od !== e.data) begin
          failures++;
          $display("FAIL commit_out f%0d ch%0d got ch=%0d data=%0d exp ch=%0d data=%0d",
                   k, c, och, od, e.ch, e.data);
        end
        if (c == 2) begin
          checks++;
          if (od !== gen(2000, 2, (k == 5) ? 5 : 3)) begin
            failures++;
            $display("FAIL commit_ch2 f%0d got=%0d exp=%0d", k, od, gen(2000, 2, (k == 5) ? 5 : 3));
          end
        end
      end
    end
  endtask

  task automatic test_seq_err();
    bit ok; int lat; logic [CW-1:0] och; pcm_t od; exp_t e; bit acc; int bad;
    xfer(0, gen(2000, 0, 7), 1'b0, 0, 0, ok, lat, och, od, e);
    checks++;
    if (!ok || och !== e.ch || od !== e.data) begin
      failures++;
      $display("FAIL seq_pre got ch=%0d data=%0d exp ch=%0d data=%0d", och, od, e.ch, e.data);
    end
    drive_in(CW'(2), pcm_t'(12345), 1'b0, '0, '0, acc);
    @(negedge clk);
    checks++;
    if (!acc || seq_err !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL seq_err_pulse got acc=%b seq_err=%b in_ready=%b exp 1 1 1", acc, seq_err, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (seq_err !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL seq_err_quiet got %0d noisy cycles exp 0", bad);
    end
    for (int c = 1; c < NCH; c++) begin
      xfer(c, (c == 1) ? pcm_t'(71) : gen(2000, c, 7), 1'b0, 0, 0, ok, lat, och, od, e);
      checks++;
      if (!ok || och !== e.ch || od !== e.data || lat != 3) begin
        failures++;
        $display("FAIL seq_post ch%0d got ch=%0d data=%0d lat=%0d exp ch=%0d data=%0d lat=3",
                 c, och, od, lat, e.ch, e.data);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [CW-1:0] och; pcm_t od; exp_t e; bit acc; int bad;
    pcm_t held;
    drive_in(CW'(0), gen(2000, 0, 8), 1'b0, '0, '0, acc);
    out_ready = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (!acc || lat != 3) begin
      failures++;
      $display("FAIL bp_latency got acc=%b lat=%0d exp 1 3", acc, lat);
    end
    held = out_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable got %0d unstable cycles exp 0", bad);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (held !== e.data || out_ch !== e.ch) begin
      failures++;
      $display("FAIL bp_data got ch=%0d data=%0d exp ch=%0d data=%0d", out_ch, held, e.ch, e.data);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b exp 1 0", out_valid, in_ready);
    end
    for (int c = 1; c < NCH; c++) begin
      xfer(c, (c == 1) ? pcm_t'(81) : gen(2000, c, 8), 1'b0, 0, 0, ok, lat, och, od, e);
      checks++;
      if (!ok || och !== e.ch || od !== e.data || lat != 3) begin
        failures++;
        $display("FAIL bp_next ch%0d got ch=%0d data=%0d lat=%0d exp ch=%0d data=%0d lat=3",
                 c, och, od, lat, e.ch, e.data);
      end
    end
  endtask

  task automatic test_wrap_reset();
    bit ok; int lat; logic [CW-1:0] och; pcm_t od; exp_t e; bit acc; int bad;
    do_reset();
    for (int c = 0; c < NCH; c++) do_cfg(c, 7);
    for (int k = 0; k < 20; k++) begin
      for (int c = 0; c < NCH; c++) begin
        xfer(c, gen(3000, c, k), 1'b0, 0, 0, ok, lat, och, od, e);
        checks++;
        if (!ok || och !== e.ch || od !== e.data) begin
          failures++;
          $display("FAIL wrap_out f%0d ch%0d got ch=%0d data=%0d exp ch=%0d data=%0d",
                   k, c, och, od, e.ch, e.data);
        end
      end
    end
    drive_in(CW'(0), gen(3000, 0, 20), 1'b0, '0, '0, acc);
    rst = 1'b1;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || seq_err !== 1'b0) bad++;
    end
    checks++;
    if (!acc || bad != 0) begin
      failures++;
      $display("FAIL rst_midwr got acc=%b noisy=%0d exp 1 0", acc, bad);
    end
    for (int c = 0; c < NCH; c++) do_cfg(c, 7);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < NCH; c++) begin
        xfer(c, gen(60000, c, k), 1'b0, 0, 0, ok, lat, och, od, e);
        checks++;
        if (!ok || och !== e.ch || od !== e.data) begin
          failures++;
          $display("FAIL post_rst_out f%0d ch%0d got ch=%0d data=%0d exp ch=%0d data=%0d",
                   k, c, och, od, e.ch, e.data);
        end
        checks++;
        if (od !== ((k < 7) ? pcm_t'(0) : gen(60000, c, 0))) begin
          failures++;
          $display("FAIL post_rst_fill f%0d ch%0d got=%0d exp=%0d", k, c, od,
                   (k < 7) ? pcm_t'(0) : gen(60000, c, 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_cfg_commit();
    test_seq_err();
    test_backpressure();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
